schoolmips_top: RTL and testbench
=================================

// Module: schoolmips_top
// PURPOSE
// - Top level of the schoolMIPS CPU: clock divider, instruction ROM, 5-stage pipelined MIPS core (F/D/E/M/W).
// - Provides a debug port that reads any register-file entry combinationally.
// - The bench loads a hex program into the ROM, then samples pipeline stage instructions, register file and fetch address every cpu clock.
// PARAMETERS
// - ROM_WORDS   64   instruction ROM depth in 32-bit words; hierarchical array reset_rom.rom[0:ROM_WORDS-1], loaded via $readmemh
// - DIV_SHIFT   0    extra divider offset: divided clock = counter bit [DIV_SHIFT+clkDevide]
// - bypass      0    parameter of the divider instance sm_clk_divider; 1 -> clk = clkIn
// PORTS
// - clkIn      in   1   board clock; the design has one clock
// - rst_n      in   1   asynchronous active-low reset
// - clkDevide  in   4   divider select (log2 of division)
// - clkEnable  in   1   1 = divider counter runs; 0 = cpu clock frozen (bypass=0 only)
// - clk        out  1   cpu clock actually driving the core
// - regAddr    in   5   debug register index
// - regData    out  32  rf[regAddr]; 0 when regAddr==0
// BEHAVIOUR
// - Divider: 32-bit counter on clkIn, cleared by rst_n, +1 per edge while clkEnable.
//   clk = bypass ? clkIn : cnt[DIV_SHIFT+clkDevide].
// - Core registers: async clear on rst_n low. PC=0, all stage instruction regs=0 (nop), rf[0..31]=0. Core runs on clk.
// - Hierarchical signals are visible by name in the core instance sm_cpu:
//   instr_F, instr_D, instr_E, instr_M, instr_W, rf.rf[0:31], imAddr.
// - imAddr = PC[31:2], ROM word address. instr_F = rom[imAddr], combinational; out-of-range address returns 0.
// - Pipeline: each posedge clk shifts F->D->E->M->W; a bubble or flushed slot holds 32'h0.
// - Supported ISA:
//   R-type: addu, subu, and, or, slt, sltu, sll, srl.
//   I-type: addiu (sign-ext), andi/ori (zero-ext), lui.
//   Branches: beq, bne.
//   Any other opcode executes as nop and writes nothing.
// - Writeback: rd for R-type, rt for I-type. Writes to $0 are ignored.
//   Value written at posedge ending W. RF read in D sees a same-cycle W write (write-through).
// - Forwarding into E operands: M result first, then W result. No load instructions, so no stalls.
// - Arithmetic is 32-bit wrap-around; no overflow traps. slt is signed, sltu unsigned.
//   Shifts use shamt[10:6] and operand rt.
// - Branches resolve in E.
//   Target = PC_branch + 4 + (sext(imm16) << 2); no delay slot.
//   When taken: PC <= target, instr_D and instr_E for the next cycle become 0 (2-cycle penalty).
//   Not taken: fall through, no penalty. A branch to self loops forever.
// - PC wraps modulo 2^32. Reset mid-operation clears the pipeline immediately and restarts fetch at 0; rf is cleared.
// - regData is combinational from rf and reflects a write on the edge after that write.
// TESTING
// - Reset, bypass=1: hold rst_n low 7 clkIn cycles.
//   -> imAddr=0, instr_D..W=0. imAddr increments by 1 per clk after release.
// - Dependent ALU ops: addiu $1,$0,5; addiu $2,$1,3; subu $3,$2,$1.
//   -> rf[1]=5, rf[2]=8, rf[3]=3, reached via forwarding with no stall.
// - lui $4,0x1234; ori $4,$4,0x5678; srl $5,$4,4; slt $6,$5,$4 with $4 negative case.
//   -> rf[4]=0x12345678, rf[5]=0x01234567, rf[6]=1.
// - Countdown loop: addiu $1,$0,3; loop: addiu $1,$1,-1; bne $1,$0,loop; addiu $7,$0,9.
//   -> loop body runs 3 times, final rf[1]=0, rf[7]=9.
//   -> on each taken branch, D/E hold 0 for one cycle.
// - Debug port and $0: addiu $0,$0,7; then regAddr=0 -> regData=0.
//   regAddr=2 after the test-2 program -> regData=8.
// - Divider: bypass=0, DIV_SHIFT=0, clkDevide=1, clkEnable=1 -> clk period = 4 clkIn periods.
//   clkEnable=0 -> clk holds its level, PC frozen.

Source files
------------

// File: rtl/schoolmips_top.sv
// schoolMIPS top level: clock divider, instruction ROM and a 5-stage pipelined core.
// A debug port reads any register-file entry combinationally.

module sm_clk_divider #(
  parameter int DIV_SHIFT = 0,
  parameter bit bypass    = 1'b0
) (
  input  logic       clkIn_i,
  input  logic       rst_ni,
  input  logic [3:0] devide_i,
  input  logic       enable_i,
  output logic       clkOut_o
);
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [4:0]  bitSel;

  assign cnt_d = enable_i ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clkIn_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign bitSel   = 5'(DIV_SHIFT) + {1'b0, devide_i};
  assign clkOut_o = bypass ? clkIn_i : cnt_q[bitSel];
endmodule

module sm_rom #(
  parameter int WORDS = 64
) (
  input  logic [29:0] a_i,
  output logic [31:0] rd_o
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0] rom [0:WORDS-1];

  // Addresses past the end of the array read as nop.
  assign rd_o = (a_i < 30'(WORDS)) ? rom[a_i[AW-1:0]] : 32'h0;
endmodule

module sm_register_file (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  a1_i,
  input  logic [4:0]  a2_i,
  input  logic [4:0]  a3_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  output logic [31:0] rd3_o,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic        we_i
);
  logic [31:0] rf [0:31];
  logic        wrValid;

  assign wrValid = we_i && (wa_i != 5'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wrValid) begin
      rf[wa_i] <= wd_i;
    end
  end

  // Decode-stage ports see a same-cycle writeback; the debug port does not.
  assign rd1_o = (wrValid && (wa_i == a1_i)) ? wd_i : rf[a1_i];
  assign rd2_o = (wrValid && (wa_i == a2_i)) ? wd_i : rf[a2_i];
  assign rd3_o = rf[a3_i];
endmodule

module sm_cpu (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [29:0] imAddr,
  input  logic [31:0] imData_i,
  input  logic [4:0]  regAddr_i,
  output logic [31:0] regData_o
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  // Returns {writeEnable, destReg}; unsupported encodings write nothing.
  function automatic logic [5:0] destOf(input logic [31:0] ins);
    logic [5:0] res;
    res = 6'd0;
    case (ins[31:26])
      OP_RTYPE:
        if (ins[5:0] inside {FN_SLL, FN_SRL, FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLTU})
          res = {1'b1, ins[15:11]};
      OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: res = {1'b1, ins[20:16]};
      default: res = 6'd0;
    endcase
    return res;
  endfunction

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_F, instr_D, instr_E, instr_M, instr_W;
  logic [31:0] instrD_d, instrE_d;
  logic [31:0] pcDec_q, pcExe_q;
  logic [31:0] srcAExe_q, srcBExe_q;
  logic [31:0] resMem_q, resWb_q;
  logic [31:0] rd1, rd2;
  logic [5:0]  destM, destW;
  logic [31:0] fwdA, fwdB;
  logic [31:0] aluRes, sext, zext, branchTarget;
  logic        branchTaken;

  assign instr_F = imData_i;
  assign imAddr  = pc_q[31:2];
  assign destM   = destOf(instr_M);
  assign destW   = destOf(instr_W);

  sm_register_file rf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .a1_i   (instr_D[25:21]),
    .a2_i   (instr_D[20:16]),
    .a3_i   (regAddr_i),
    .rd1_o  (rd1),
    .rd2_o  (rd2),
    .rd3_o  (regData_o),
    .wa_i   (destW[4:0]),
    .wd_i   (resWb_q),
    .we_i   (destW[5])
  );

  // Operand bypass into execute: the younger M result wins over W.
  always_comb begin
    fwdA = srcAExe_q;
    fwdB = srcBExe_q;
    if (destM[5] && destM[4:0] != 5'd0 && destM[4:0] == instr_E[25:21]) fwdA = resMem_q;
    else if (destW[5] && destW[4:0] != 5'd0 && destW[4:0] == instr_E[25:21]) fwdA = resWb_q;
    if (destM[5] && destM[4:0] != 5'd0 && destM[4:0] == instr_E[20:16]) fwdB = resMem_q;
    else if (destW[5] && destW[4:0] != 5'd0 && destW[4:0] == instr_E[20:16]) fwdB = resWb_q;
  end

  always_comb begin
    sext         = {{16{instr_E[15]}}, instr_E[15:0]};
    zext         = {16'h0, instr_E[15:0]};
    branchTarget = pcExe_q + 32'd4 + {sext[29:0], 2'b00};
    aluRes       = '0;
    branchTaken  = 1'b0;
    case (instr_E[31:26])
      OP_RTYPE:
        case (instr_E[5:0])
          FN_ADDU: aluRes = fwdA + fwdB;
          FN_SUBU: aluRes = fwdA - fwdB;
          FN_AND:  aluRes = fwdA & fwdB;
          FN_OR:   aluRes = fwdA | fwdB;
          FN_SLT:  aluRes = {31'd0, $signed(fwdA) < $signed(fwdB)};
          FN_SLTU: aluRes = {31'd0, fwdA < fwdB};
          FN_SLL:  aluRes = fwdB << instr_E[10:6];
          FN_SRL:  aluRes = fwdB >> instr_E[10:6];
          default: aluRes = '0;
        endcase
      OP_ADDIU: aluRes = fwdA + sext;
      OP_ANDI:  aluRes = fwdA & zext;
      OP_ORI:   aluRes = fwdA | zext;
      OP_LUI:   aluRes = {instr_E[15:0], 16'h0};
      OP_BEQ:   branchTaken = (fwdA == fwdB);
      OP_BNE:   branchTaken = (fwdA != fwdB);
      default:  aluRes = '0;
    endcase
  end

  // A taken branch in E squashes the two younger instructions in F and D.
  always_comb begin
    pc_d     = branchTaken ? branchTarget : pc_q + 32'd4;
    instrD_d = branchTaken ? 32'h0 : instr_F;
    instrE_d = branchTaken ? 32'h0 : instr_D;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= '0;
      instr_D   <= '0;
      instr_E   <= '0;
      instr_M   <= '0;
      instr_W   <= '0;
      pcDec_q   <= '0;
      pcExe_q   <= '0;
      srcAExe_q <= '0;
      srcBExe_q <= '0;
      resMem_q  <= '0;
      resWb_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_D   <= instrD_d;
      instr_E   <= instrE_d;
      instr_M   <= instr_E;
      instr_W   <= instr_M;
      pcDec_q   <= pc_q;
      pcExe_q   <= pcDec_q;
      srcAExe_q <= rd1;
      srcBExe_q <= rd2;
      resMem_q  <= aluRes;
      resWb_q   <= resMem_q;
    end
  end
endmodule

module schoolmips_top #(
  parameter int ROM_WORDS = 64,
  parameter int DIV_SHIFT = 0,
  parameter bit bypass    = 1'b0
) (
  input  logic        clkIn,
  input  logic        rst_n,
  input  logic [3:0]  clkDevide,
  input  logic        clkEnable,
  output logic        clk,
  input  logic [4:0]  regAddr,
  output logic [31:0] regData
);
  logic [29:0] imAddr;
  logic [31:0] imData;

  sm_clk_divider #(
    .DIV_SHIFT (DIV_SHIFT),
    .bypass    (bypass)
  ) sm_clk_divider (
    .clkIn_i  (clkIn),
    .rst_ni   (rst_n),
    .devide_i (clkDevide),
    .enable_i (clkEnable),
    .clkOut_o (clk)
  );

  sm_rom #(.WORDS(ROM_WORDS)) reset_rom (
    .a_i  (imAddr),
    .rd_o (imData)
  );

  sm_cpu sm_cpu (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .imAddr    (imAddr),
    .imData_i  (imData),
    .regAddr_i (regAddr),
    .regData_o (regData)
  );
endmodule

// File: tb/tb_schoolmips_top.sv
// Bench for schoolmips_top: directed MIPS programs with a queued scoreboard,
// plus a second instance exercising the real clock divider.
module tb_schoolmips_top;
  localparam int K_IMADDR  = 0;
  localparam int K_INSTR_D = 1;
  localparam int K_INSTR_E = 2;
  localparam int K_INSTR_M = 3;
  localparam int K_INSTR_W = 4;
  localparam int K_RF      = 5;
  localparam int K_DBG     = 6;
  localparam int K_DCLK    = 7;
  localparam int K_DIMADDR = 8;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } chk_t;

  logic        clkIn;
  logic        rst_n, rstDiv_n;
  logic [3:0]  clkDevide;
  logic        clkEnable, divEnable;
  logic        cpuClk, divClk;
  logic [4:0]  regAddr;
  logic [31:0] regData, divRegData;
  logic [31:0] progBuf [0:63];
  chk_t        expQ [$];
  int          checks = 0;
  int          errors = 0;

  schoolmips_top #(.ROM_WORDS(64), .DIV_SHIFT(0), .bypass(1'b1)) dut (
    .clkIn(clkIn), .rst_n(rst_n), .clkDevide(clkDevide), .clkEnable(clkEnable),
    .clk(cpuClk), .regAddr(regAddr), .regData(regData)
  );

  schoolmips_top #(.ROM_WORDS(64), .DIV_SHIFT(0), .bypass(1'b0)) dutDiv (
    .clkIn(clkIn), .rst_n(rstDiv_n), .clkDevide(4'd1), .clkEnable(divEnable),
    .clk(divClk), .regAddr(regAddr), .regData(divRegData)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  function automatic logic [31:0] encI(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] encR(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] probe(input int kind, input int idx);
    case (kind)
      K_IMADDR:  return {2'b00, dut.sm_cpu.imAddr};
      K_INSTR_D: return dut.sm_cpu.instr_D;
      K_INSTR_E: return dut.sm_cpu.instr_E;
      K_INSTR_M: return dut.sm_cpu.instr_M;
      K_INSTR_W: return dut.sm_cpu.instr_W;
      K_RF:      return dut.sm_cpu.rf.rf[idx[4:0]];
      K_DBG:     return regData;
      K_DCLK:    return {31'd0, divClk};
      K_DIMADDR: return {2'b00, dutDiv.sm_cpu.imAddr};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: every expectation queued before a falling edge is compared there.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clkIn);
      while (expQ.size() > 0) begin
        c   = expQ.pop_front();
        act = probe(c.kind, c.idx);
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input int kind, input int idx, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.idx  = idx;
    c.exp  = exp;
    expQ.push_back(c);
  endtask

  task automatic step();
    @(posedge clkIn);
    #1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 20) begin
      @(negedge clkIn);
      #1;
      n++;
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic clearProg();
    for (int i = 0; i < 64; i++) progBuf[i] = 32'h0;
  endtask

  // Reset the core for seven cycles, load progBuf, check the cleared state, release.
  task automatic applyStimulus();
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) dut.reset_rom.rom[i] = progBuf[i];
    repeat (7) step();
    checkOutput("rst_imAddr", K_IMADDR, 0, 32'd0);
    checkOutput("rst_instrD", K_INSTR_D, 0, 32'd0);
    checkOutput("rst_instrE", K_INSTR_E, 0, 32'd0);
    checkOutput("rst_instrM", K_INSTR_M, 0, 32'd0);
    checkOutput("rst_instrW", K_INSTR_W, 0, 32'd0);
    checkOutput("rst_rf1", K_RF, 1, 32'd0);
    checkOutput("rst_rf2", K_RF, 2, 32'd0);
    waitDrain();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] bneWord, beqWord, addi7Word;
    rst_n     = 1'b0;
    rstDiv_n  = 1'b0;
    clkDevide = 4'd0;
    clkEnable = 1'b1;
    divEnable = 1'b1;
    regAddr   = 5'd0;
    for (int i = 0; i < 64; i++) dutDiv.reset_rom.rom[i] = 32'h0;

    // Dependent ALU chain: needs M and W forwarding, must not stall.
    clearProg();
    progBuf[0] = encI(9, 0, 1, 5);
    progBuf[1] = encI(9, 1, 2, 3);
    progBuf[2] = encR(2, 1, 3, 0, 35);
    applyStimulus();
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k <= 3) checkOutput("fetch_incr", K_IMADDR, 0, 32'(k));
      if (k == 5) checkOutput("rf1_first", K_RF, 1, 32'd5);
      if (k == 6) begin
        regAddr = 5'd3;
        checkOutput("rf3_before", K_RF, 3, 32'd0);
        checkOutput("dbg3_before", K_DBG, 0, 32'd0);
      end
      if (k == 7) begin
        checkOutput("rf1", K_RF, 1, 32'd5);
        checkOutput("rf2", K_RF, 2, 32'd8);
        checkOutput("rf3", K_RF, 3, 32'd3);
        checkOutput("dbg3_after", K_DBG, 0, 32'd3);
      end
    end
    waitDrain();
    regAddr = 5'd2;
    checkOutput("dbg2", K_DBG, 0, 32'd8);
    waitDrain();

    // Logic, shifts, compares and immediates; the final instruction targets $0.
    clearProg();
    progBuf[0]  = encI(15, 0, 4, 16'h1234);
    progBuf[1]  = encI(13, 4, 4, 16'h5678);
    progBuf[2]  = encR(0, 4, 5, 4, 2);
    progBuf[3]  = encR(5, 4, 6, 0, 42);
    progBuf[4]  = encI(15, 0, 8, 16'h8000);
    progBuf[5]  = encR(8, 4, 9, 0, 42);
    progBuf[6]  = encR(8, 4, 10, 0, 43);
    progBuf[7]  = encR(0, 4, 11, 4, 0);
    progBuf[8]  = encR(4, 5, 12, 0, 36);
    progBuf[9]  = encI(9, 0, 13, -1);
    progBuf[10] = encI(12, 13, 14, 16'h8001);
    progBuf[11] = encR(8, 5, 15, 0, 37);
    progBuf[12] = encI(9, 0, 0, 7);
    applyStimulus();
    repeat (25) step();
    checkOutput("lui_ori", K_RF, 4, 32'h1234_5678);
    checkOutput("srl", K_RF, 5, 32'h0123_4567);
    checkOutput("slt_pos", K_RF, 6, 32'd1);
    checkOutput("lui_neg", K_RF, 8, 32'h8000_0000);
    checkOutput("slt_neg", K_RF, 9, 32'd1);
    checkOutput("sltu_neg", K_RF, 10, 32'd0);
    checkOutput("sll", K_RF, 11, 32'h2345_6780);
    checkOutput("and", K_RF, 12, 32'h0020_4460);
    checkOutput("addiu_neg", K_RF, 13, 32'hFFFF_FFFF);
    checkOutput("andi_zext", K_RF, 14, 32'h0000_8001);
    checkOutput("or", K_RF, 15, 32'h8123_4567);
    checkOutput("rf0", K_RF, 0, 32'd0);
    regAddr = 5'd0;
    checkOutput("dbg0", K_DBG, 0, 32'd0);
    waitDrain();
    regAddr = 5'd14;
    checkOutput("dbg14", K_DBG, 0, 32'h0000_8001);
    waitDrain();

    // Countdown loop, then a branch-to-self.
    clearProg();
    bneWord    = encI(5, 1, 0, -2);
    addi7Word  = encI(9, 0, 7, 9);
    beqWord    = encI(4, 0, 0, -1);
    progBuf[0] = encI(9, 0, 1, 3);
    progBuf[1] = encI(9, 1, 1, -1);
    progBuf[2] = bneWord;
    progBuf[3] = addi7Word;
    progBuf[4] = beqWord;
    applyStimulus();
    for (int k = 1; k <= 30; k++) begin
      step();
      case (k)
        4, 8, 12: checkOutput("bne_in_E", K_INSTR_E, 0, bneWord);
        5, 9: begin
          checkOutput("flush_D", K_INSTR_D, 0, 32'd0);
          checkOutput("flush_E", K_INSTR_E, 0, 32'd0);
          checkOutput("bne_in_M", K_INSTR_M, 0, bneWord);
          checkOutput("bne_target", K_IMADDR, 0, 32'd1);
        end
        13: begin
          checkOutput("fall_D", K_INSTR_D, 0, beqWord);
          checkOutput("fall_E", K_INSTR_E, 0, addi7Word);
          checkOutput("fall_pc", K_IMADDR, 0, 32'd5);
        end
        15: begin
          checkOutput("self_D", K_INSTR_D, 0, 32'd0);
          checkOutput("self_pc", K_IMADDR, 0, 32'd4);
        end
        30: begin
          checkOutput("loop_rf1", K_RF, 1, 32'd0);
          checkOutput("loop_rf7", K_RF, 7, 32'd9);
          checkOutput("self_loop_pc", K_IMADDR, 0, 32'd4);
        end
        default: ;
      endcase
    end
    waitDrain();

    // Real divider: clkDevide=1 gives clk = cnt[1], a period of four board clocks.
    step();
    rstDiv_n = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      step();
      checkOutput("div_clk", K_DCLK, 0, 32'((n >> 1) & 1));
      if (n == 6) checkOutput("div_pc", K_DIMADDR, 0, 32'd2);
    end
    divEnable = 1'b0;
    repeat (6) begin
      step();
      checkOutput("frozen_clk", K_DCLK, 0, 32'd1);
      checkOutput("frozen_pc", K_DIMADDR, 0, 32'd2);
    end
    divEnable = 1'b1;
    step();
    checkOutput("resume_clk_lo", K_DCLK, 0, 32'd0);
    step();
    step();
    checkOutput("resume_clk_hi", K_DCLK, 0, 32'd1);
    checkOutput("resume_pc", K_DIMADDR, 0, 32'd3);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
